fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the CPU32 execute/ALU stage and supplies its instruction word (pmDataIn).
- Holds the PC and issues word reads to the synchronous program memory (MEM_SIZE words, 1-cycle read latency).
- Buffers returned words with their PC in a small FIFO.
- Presents them to decode/execute with a valid/ready handshake.
- A redirect input (taken branch/jump from OP_BRANCH resolution) flushes everything in flight and restarts fetch at the new PC.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 80 ++++++++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU32 definitions: memory geometry, reset PC, opcode constants and
// the fetch-entry record that travels from fetch to decode/execute.
package cpu_pkg;

  localparam int XLEN     = 32;
  localparam int ILEN     = 32;
  localparam int MEM_SIZE = 1024;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // RV32-style major opcodes used by the execute stage.
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // One buffered instruction together with the byte address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetch is word-granular; the low two address bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. Flush empties it in one edge and
// takes priority over a push in the same cycle. DEPTH must be a power of two
// so the pointers wrap by simple overflow.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  fetch_entry_t     wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // Writes into a full FIFO and reads from an empty one are ignored.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state for pointers and occupancy; flush wins over push and pop.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; a flushed push is dropped.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q alone decides which entries are live.
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding CPU32 decode/execute. Owns the PC, issues
// word reads to 1-cycle-latency program memory, buffers returned words with
// their PC and hands them downstream with a valid/ready handshake. A redirect
// flushes everything in flight and restarts fetch at the new PC.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = cpu_pkg::RESET_PC,
  parameter int          PM_ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter int          FIFO_DEPTH    = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     pm_read,
  output logic [PM_ADDR_WIDTH-1:0] pm_addr,
  input  logic [31:0]              pm_data_in,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  rd_pc_q, rd_pc_d;     // PC of the read currently in flight
  logic             inflight_q, inflight_d;
  logic             kill_q, kill_d;       // discard the next response

  logic             fifo_push;
  logic             fifo_pop;
  fetch_entry_t     fifo_wdata;
  fetch_entry_t     fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;

  logic [CNT_W:0]   credits_used;
  logic             issue;

  // Downstream handshake; a redirect hides the head so nothing is consumed.
  assign instr_valid = !fifo_empty && !redirect_valid;
  assign fifo_pop    = instr_valid && instr_ready;
  assign instr       = fifo_empty ? '0 : fifo_rdata.instr;
  assign instr_pc    = fifo_empty ? '0 : fifo_rdata.pc;

  // Every read reserves a slot: buffered entries plus the outstanding read,
  // less the entry leaving this cycle, must stay below the depth.
  assign credits_used = {1'b0, fifo_count}
                      + (CNT_W+1)'(inflight_q)
                      - (CNT_W+1)'(fifo_pop);
  assign issue = reset && !redirect_valid
              && (credits_used < (CNT_W+1)'(FIFO_DEPTH));

  assign pm_read = issue;
  assign pm_addr = pc_q[PM_ADDR_WIDTH+1:2];

  // A response is buffered unless it was killed or a redirect is flushing.
  assign fifo_push  = inflight_q && !kill_q && !redirect_valid;
  assign fifo_wdata = '{pc: rd_pc_q, instr: pm_data_in};

  // PC, in-flight and kill bookkeeping; redirect overrides everything.
  always_comb begin
    pc_d       = pc_q;
    rd_pc_d    = rd_pc_q;
    inflight_d = inflight_q;
    kill_d     = kill_q;
    if (redirect_valid) begin
      pc_d       = align_pc(redirect_pc);
      inflight_d = 1'b0;
      kill_d     = 1'b1;
    end else if (issue) begin
      pc_d       = pc_q + 32'd4;
      rd_pc_d    = pc_q;
      inflight_d = 1'b1;
      kill_d     = 1'b0;
    end else begin
      inflight_d = 1'b0;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      rd_pc_q    <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rd_pc_q    <= rd_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .flush_i (redirect_valid),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall, redirect, address
// wrap, back-to-back redirects and asynchronous mid-stream reset. A second
// instance starts near the top of the 32-bit PC space to check PC wrap.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        pm_read;
  logic [9:0]  pm_addr;
  logic [31:0] pm_data_in;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic        pm_read2;
  logic [9:0]  pm_addr2;
  logic [31:0] pm_data_in2;
  logic        instr_valid2;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;
  logic        instr_ready2    = 1'b1;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2    = 32'h0;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(32'h0000_0000), .PM_ADDR_WIDTH(10), .FIFO_DEPTH(2)) u_dut (
    .clock(clock), .reset(reset), .pm_read(pm_read), .pm_addr(pm_addr),
    .pm_data_in(pm_data_in), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .PM_ADDR_WIDTH(10), .FIFO_DEPTH(2)) u_dut2 (
    .clock(clock), .reset(reset), .pm_read(pm_read2), .pm_addr(pm_addr2),
    .pm_data_in(pm_data_in2), .instr_valid(instr_valid2), .instr_ready(instr_ready2),
    .instr(instr2), .instr_pc(instr_pc2), .redirect_valid(redirect_valid2),
    .redirect_pc(redirect_pc2)
  );

  // Memory word k is "addi x0,x0,k": 32'h13 + (k << 20).
  function automatic logic [31:0] mem_word(input logic [9:0] k);
    return {25'd0, OP_OP_IMM} + ({22'd0, k} << 20);
  endfunction

  // Synchronous program memories, one-cycle read latency.
  initial pm_data_in  = 32'h0;
  initial pm_data_in2 = 32'h0;
  always @(posedge clock) if (pm_read)  pm_data_in  <= mem_word(pm_addr);
  always @(posedge clock) if (pm_read2) pm_data_in2 <= mem_word(pm_addr2);

  // FIFO must never be written when full nor popped when empty.
  always @(posedge clock) begin
    if (reset) begin
      if (u_dut.u_fifo.push_i && u_dut.u_fifo.full_o && !u_dut.u_fifo.flush_i) begin
        errors++;
        $display("FAIL fifo_overflow: push while full at %0t", $time);
      end
      if (u_dut.u_fifo.pop_i && u_dut.u_fifo.empty_o) begin
        errors++;
        $display("FAIL fifo_underflow: pop while empty at %0t", $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Assert reset, then release it on a falling edge: the caller is then in cycle 0.
  task automatic start_fetch();
    @(negedge clock);
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    #1;
    checks++; if (pm_read !== 1'b0) begin errors++; $display("FAIL reset_pm_read: got %b want 0", pm_read); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
    checks++; if (pm_read2 !== 1'b0) begin errors++; $display("FAIL reset_pm_read2: got %b want 0", pm_read2); end
  endtask

  task automatic test_stream();
    instr_ready = 1'b1;
    start_fetch();
    #1;
    checks++; if (pm_read !== 1'b1 || pm_addr !== 10'd0) begin errors++; $display("FAIL stream_c0_read: got read=%b addr=%0d want 1/0", pm_read, pm_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_c0_valid: got %b want 0", instr_valid); end
    @(negedge clock); #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_c1_valid: got %b want 0", instr_valid); end
    checks++; if (pm_read !== 1'b1 || pm_addr !== 10'd1) begin errors++; $display("FAIL stream_c1_read: got read=%b addr=%0d want 1/1", pm_read, pm_addr); end
    for (int c = 2; c < 12; c++) begin
      @(negedge clock); #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (c - 2)) || instr !== mem_word(10'(c - 2))) begin
        errors++;
        $display("FAIL stream_c%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                 c, instr_valid, instr_pc, instr, 32'(4 * (c - 2)), mem_word(10'(c - 2)));
      end
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b1;
    start_fetch();
    repeat (2) @(negedge clock);   // now in cycle 2, pc 0 is consumed
    for (int c = 3; c < 9; c++) begin
      @(negedge clock);
      instr_ready = 1'b0;
      #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== mem_word(10'd1)) begin
        errors++;
        $display("FAIL stall_hold_c%0d: got v=%b pc=%h i=%h want v=1 pc=4 i=%h",
                 c, instr_valid, instr_pc, instr, mem_word(10'd1));
      end
      if (c >= 5) begin
        checks++;
        if (pm_read !== 1'b0) begin errors++; $display("FAIL stall_read_c%0d: got %b want 0", c, pm_read); end
      end
    end
    for (int c = 9; c < 15; c++) begin
      @(negedge clock);
      instr_ready = 1'b1;
      #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (c - 8)) || instr !== mem_word(10'(c - 8))) begin
        errors++;
        $display("FAIL stall_resume_c%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                 c, instr_valid, instr_pc, instr, 32'(4 * (c - 8)), mem_word(10'(c - 8)));
      end
    end
  endtask

  task automatic test_redirect();
    instr_ready = 1'b1;
    start_fetch();
    repeat (2) @(negedge clock);   // cycle 2
    // Cycle 3: one entry buffered, one read in flight, consumer stalled.
    @(negedge clock);
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_r_valid: got %b want 0", instr_valid); end
    checks++; if (pm_read !== 1'b0) begin errors++; $display("FAIL redir_r_read: got %b want 0", pm_read); end
    @(negedge clock);
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_r1_valid: got %b want 0", instr_valid); end
    checks++; if (pm_read !== 1'b1 || pm_addr !== 10'd64) begin errors++; $display("FAIL redir_r1_read: got read=%b addr=%0d want 1/64", pm_read, pm_addr); end
    @(negedge clock); #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_r2_stale: got v=%b pc=%h want v=0", instr_valid, instr_pc); end
    @(negedge clock); #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem_word(10'd64)) begin
      errors++;
      $display("FAIL redir_r3_target: got v=%b pc=%h i=%h want v=1 pc=100 i=%h", instr_valid, instr_pc, instr, mem_word(10'd64));
    end
    @(negedge clock); #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h104 || instr !== mem_word(10'd65)) begin
      errors++;
      $display("FAIL redir_r4_next: got v=%b pc=%h i=%h want v=1 pc=104 i=%h", instr_valid, instr_pc, instr, mem_word(10'd65));
    end
  endtask

  task automatic test_addr_wrap();
    instr_ready = 1'b1;
    start_fetch();
    repeat (3) @(negedge clock);   // cycle 3
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0FFC;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_r_valid: got %b want 0", instr_valid); end
    @(negedge clock);
    redirect_valid = 1'b0;
    #1;
    checks++; if (pm_read !== 1'b1 || pm_addr !== 10'd1023) begin errors++; $display("FAIL wrap_addr_1023: got read=%b addr=%0d want 1/1023", pm_read, pm_addr); end
    @(negedge clock); #1;
    checks++; if (pm_read !== 1'b1 || pm_addr !== 10'd0) begin errors++; $display("FAIL wrap_addr_0: got read=%b addr=%0d want 1/0", pm_read, pm_addr); end
    @(negedge clock); #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0FFC || instr !== mem_word(10'd1023)) begin
      errors++;
      $display("FAIL wrap_ffc: got v=%b pc=%h i=%h want v=1 pc=ffc i=%h", instr_valid, instr_pc, instr, mem_word(10'd1023));
    end
    @(negedge clock); #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h1000 || instr !== mem_word(10'd0)) begin
      errors++;
      $display("FAIL wrap_1000: got v=%b pc=%h i=%h want v=1 pc=1000 i=%h", instr_valid, instr_pc, instr, mem_word(10'd0));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] targets [3];
    targets[0] = 32'h40;
    targets[1] = 32'h80;
    targets[2] = 32'hC0;
    instr_ready = 1'b1;
    start_fetch();
    repeat (2) @(negedge clock);   // cycle 2
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      redirect_valid = 1'b1;
      redirect_pc = targets[i];
      #1;
      checks++; if (instr_valid !== 1'b0 || pm_read !== 1'b0) begin errors++; $display("FAIL b2b_redir%0d: got v=%b read=%b want 0/0", i, instr_valid, pm_read); end
    end
    @(negedge clock);
    redirect_valid = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || pm_addr !== 10'd48) begin errors++; $display("FAIL b2b_r1: got v=%b addr=%0d want 0/48", instr_valid, pm_addr); end
    @(negedge clock); #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_r2: got v=%b pc=%h want v=0", instr_valid, instr_pc); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock); #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(32'hC0 + 4 * k) || instr !== mem_word(10'(48 + k))) begin
        errors++;
        $display("FAIL b2b_seq%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                 k, instr_valid, instr_pc, instr, 32'(32'hC0 + 4 * k), mem_word(10'(48 + k)));
      end
    end
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b1;
    start_fetch();
    repeat (5) @(negedge clock);   // streaming
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (pm_read !== 1'b0) begin errors++; $display("FAIL arst_read: got %b want 0", pm_read); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL arst_data: got i=%h pc=%h want 0/0", instr, instr_pc); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (pm_read !== 1'b1 || pm_addr !== 10'd0 || instr_valid !== 1'b0) begin errors++; $display("FAIL arst_c0: got read=%b addr=%0d v=%b want 1/0/0", pm_read, pm_addr, instr_valid); end
    @(negedge clock); #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL arst_c1_residual: got v=%b pc=%h want v=0", instr_valid, instr_pc); end
    for (int c = 2; c < 4; c++) begin
      @(negedge clock); #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (c - 2)) || instr !== mem_word(10'(c - 2))) begin
        errors++;
        $display("FAIL arst_c%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                 c, instr_valid, instr_pc, instr, 32'(4 * (c - 2)), mem_word(10'(c - 2)));
      end
    end
  endtask

  task automatic test_reset_pc_wrap();
    logic [31:0] exp_pc [3];
    logic [9:0]  exp_k  [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_k[0] = 10'd1022;
    exp_pc[1] = 32'hFFFF_FFFC; exp_k[1] = 10'd1023;
    exp_pc[2] = 32'h0000_0000; exp_k[2] = 10'd0;
    start_fetch();
    #1;
    checks++; if (pm_read2 !== 1'b1 || pm_addr2 !== 10'd1022) begin errors++; $display("FAIL rpc_c0: got read=%b addr=%0d want 1/1022", pm_read2, pm_addr2); end
    @(negedge clock);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock); #1;
      checks++;
      if (instr_valid2 !== 1'b1 || instr_pc2 !== exp_pc[c] || instr2 !== mem_word(exp_k[c])) begin
        errors++;
        $display("FAIL rpc_seq%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                 c, instr_valid2, instr_pc2, instr2, exp_pc[c], mem_word(exp_k[c]));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_addr_wrap();
    test_back_to_back();
    test_async_reset();
    test_reset_pc_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
